// File: rtl/mul16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mul16_pkg                                                 |
// | Purpose  : Shared constants, Booth digit type and digit decoder for  |
// |            the signed 16x16 multiplier datapath.                     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package mul16_pkg;

  localparam int WIDTH = 16;           // operand width (tree is sized for 16)
  localparam int ROWS  = WIDTH / 2;    // radix-4 Booth rows
  localparam int PP0_W = 20;           // row 0 width
  localparam int PPN_W = 19;           // rows 1..6 width
  localparam int PP7_W = 18;           // row 7 width (bits above column 31 dropped)

  // Booth digit selector: value d in {-2,-1,0,+1,+2}
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_op_t;

  // Standard radix-4 Booth table on the triplet {y[2i+1], y[2i], y[2i-1]}
  function automatic booth_op_t booth_decode(input logic [2:0] trip);
    booth_op_t op;
    case (trip)
      3'b001, 3'b010: op = POS1;
      3'b011:         op = POS2;
      3'b100:         op = NEG2;
      3'b101, 3'b110: op = NEG1;
      default:        op = ZERO;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_row.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : booth_row                                                 |
// | Purpose  : One Booth row: computes d*x exactly and returns its low   |
// |            17 bits (two's complement) plus the sign of the product.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module booth_row
  import mul16_pkg::*;
(
  input  logic [WIDTH-1:0] x_i,
  input  booth_op_t        op_i,
  output logic [WIDTH:0]   m_o,
  output logic             s_o
);

  // 18 bits hold every d*x exactly, including +65536 for x=-32768, d=-2
  logic signed [WIDTH+1:0] x_w;
  logic signed [WIDTH+1:0] v_w;

  // Select the scaled/negated multiplicand for this digit
  always_comb begin
    x_w = {{2{x_i[WIDTH-1]}}, x_i};
    v_w = '0;
    case (op_i)
      POS1:    v_w = x_w;
      POS2:    v_w = x_w <<< 1;
      NEG1:    v_w = -x_w;
      NEG2:    v_w = -(x_w <<< 1);
      default: v_w = '0;
    endcase
  end

  assign m_o = v_w[WIDTH:0];
  assign s_o = v_w[WIDTH+1];

endmodule
`default_nettype wire

// File: rtl/booth_pp_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : booth_pp_gen                                              |
// | Purpose  : Radix-4 Booth partial-product generator, 2-stage pipeline |
// |            with valid/ready on both sides. Emits sign-extension-     |
// |            encoded rows pp0..pp7 for the Dadda compression tree.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module booth_pp_gen
  import mul16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PP0_W-1:0] pp0,
  output logic [PPN_W-1:0] pp1,
  output logic [PPN_W-1:0] pp2,
  output logic [PPN_W-1:0] pp3,
  output logic [PPN_W-1:0] pp4,
  output logic [PPN_W-1:0] pp5,
  output logic [PPN_W-1:0] pp6,
  output logic [PP7_W-1:0] pp7
);

  // Stage 1: multiplicand and decoded digits (the digits fully capture b)
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] x_q, x_d;
  booth_op_t        op_q [ROWS];
  booth_op_t        op_d [ROWS];

  // Stage 2: registered rows
  logic             out_valid_q, out_valid_d;
  logic [PP0_W-1:0] pp0_q, pp0_d;
  logic [PPN_W-1:0] ppn_q [1:ROWS-2];
  logic [PPN_W-1:0] ppn_d [1:ROWS-2];
  logic [PP7_W-1:0] pp7_q, pp7_d;

  logic             s2_adv_w;
  logic             in_xfer_w;
  logic [WIDTH:0]   y_ext_w;
  booth_op_t        op_w [ROWS];
  logic [WIDTH:0]   m_w  [ROWS];
  logic             s_w  [ROWS];

  // Handshake: stage 2 can take new data when empty or draining this cycle
  assign s2_adv_w  = !out_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_adv_w;
  assign in_xfer_w = in_valid && in_ready;

  // Multiplier with the implicit y[-1]=0 appended below bit 0
  assign y_ext_w = {b, 1'b0};

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_digit
      assign op_w[gi] = booth_decode(y_ext_w[2*gi+2 -: 3]);

      booth_row u_row (
        .x_i  (x_q),
        .op_i (op_q[gi]),
        .m_o  (m_w[gi]),
        .s_o  (s_w[gi])
      );
    end
  endgenerate

  // Stage 1 next state: load on input transfer, empty when handed to stage 2
  always_comb begin
    s1_valid_d = s1_valid_q;
    x_d        = x_q;
    op_d       = op_q;
    if (in_xfer_w) begin
      s1_valid_d = 1'b1;
      x_d        = a;
      op_d       = op_w;
    end else if (s2_adv_w) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state: rows form sign-extension-encoded partial products
  always_comb begin
    out_valid_d = out_valid_q;
    pp0_d       = pp0_q;
    ppn_d       = ppn_q;
    pp7_d       = pp7_q;
    if (s2_adv_w) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        pp0_d = {~s_w[0], s_w[0], s_w[0], m_w[0]};
        for (int i = 1; i < ROWS-1; i++) begin
          ppn_d[i] = {1'b1, ~s_w[i], m_w[i]};
        end
        pp7_d = {~s_w[ROWS-1], m_w[ROWS-1]};
      end
    end
  end

  // Pipeline registers with synchronous reset that discards in-flight items
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      x_q         <= '0;
      for (int i = 0; i < ROWS; i++) begin
        op_q[i] <= ZERO;
      end
      out_valid_q <= 1'b0;
      pp0_q       <= '0;
      for (int i = 1; i < ROWS-1; i++) begin
        ppn_q[i] <= '0;
      end
      pp7_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      x_q         <= x_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      pp0_q       <= pp0_d;
      ppn_q       <= ppn_d;
      pp7_q       <= pp7_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pp0       = pp0_q;
  assign pp1       = ppn_q[1];
  assign pp2       = ppn_q[2];
  assign pp3       = ppn_q[3];
  assign pp4       = ppn_q[4];
  assign pp5       = ppn_q[5];
  assign pp6       = ppn_q[6];
  assign pp7       = pp7_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_pp_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_booth_pp_gen                                           |
// | Purpose  : Scoreboard bench for booth_pp_gen: directed corner cases  |
// |            plus randomized traffic with random valid/ready.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_booth_pp_gen;

  localparam int N_RAND = 10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] pp0;
  logic [18:0] pp1, pp2, pp3, pp4, pp5, pp6;
  logic [17:0] pp7;

  int n_tests   = 0;
  int n_fail    = 0;
  int n_in      = 0;
  int n_out     = 0;
  int n_dropped = 0;

  logic [31:0] exp_q [$];   // accepted {a,b} pairs awaiting output

  booth_pp_gen dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pp0       (pp0),
    .pp1       (pp1),
    .pp2       (pp2),
    .pp3       (pp3),
    .pp4       (pp4),
    .pp5       (pp5),
    .pp6       (pp6),
    .pp7       (pp7)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // All eight DUT rows as one vector {pp7,...,pp0}
  function automatic logic [151:0] dut_rows();
    return {pp7, pp6, pp5, pp4, pp3, pp2, pp1, pp0};
  endfunction

  // Weighted sum of the DUT rows, mod 2^32
  function automatic logic [31:0] dut_sum();
    logic [31:0] s;
    s = 32'(pp0) + (32'(pp1) << 2) + (32'(pp2) << 4) + (32'(pp3) << 6)
      + (32'(pp4) << 8) + (32'(pp5) << 10) + (32'(pp6) << 12) + (32'(pp7) << 14);
    return s;
  endfunction

  // Reference rows from the digit value d = -2*y[2i+1] + y[2i] + y[2i-1]
  function automatic logic [151:0] model_rows(input logic [15:0] x, input logic [15:0] y);
    logic [151:0] r;
    logic [16:0]  yx;
    logic [16:0]  m;
    logic         s;
    int           xi, d, v;
    r  = '0;
    yx = {y, 1'b0};
    xi = int'($signed(x));
    for (int i = 0; i < 8; i++) begin
      d = (yx[2*i+2] ? -2 : 0) + (yx[2*i+1] ? 1 : 0) + (yx[2*i] ? 1 : 0);
      v = d * xi;
      m = v[16:0];
      s = (v < 0);
      if (i == 0)      r[19:0]              = {~s, s, s, m};
      else if (i == 7) r[151:134]           = {~s, m};
      else             r[20+19*(i-1) +: 19] = {1'b1, ~s, m};
    end
    return r;
  endfunction

  function automatic logic [31:0] model_prod(input logic [15:0] x, input logic [15:0] y);
    int xi, yi, p;
    xi = int'($signed(x));
    yi = int'($signed(y));
    p  = xi * yi;
    return 32'(p);
  endfunction

  // Scoreboard: record accepted operands, check each emitted item in order
  always @(negedge clk) begin
    logic [31:0] ent;
    if (rst) begin
      n_dropped += exp_q.size();
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back({a, b});
        n_in++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got output sum %h with no item pending", dut_sum());
        end else begin
          ent = exp_q.pop_front();
          chk("sb_rows", dut_rows(), model_rows(ent[31:16], ent[15:0]));
          chk("sb_sum", dut_sum(), model_prod(ent[31:16], ent[15:0]));
        end
      end
    end
  end

  // Offer one operand pair and hold it until accepted (bounded)
  task automatic send(input logic [15:0] xa, input logic [15:0] xb);
    int k;
    k        = 0;
    a        = xa;
    b        = xb;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", k);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Single operation: latency and row/sum spot checks
  task automatic single_op(input logic [15:0] xa, input logic [15:0] xb,
                           input logic [31:0] esum, input logic [19:0] epp0,
                           input logic [17:0] epp7);
    out_ready = 1'b1;
    send(xa, xb);
    @(negedge clk);
    chk("lat_early_out_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("lat_out_valid", out_valid, 1'b1);
    chk("single_pp0", pp0, epp0);
    chk("single_pp7", pp7, epp7);
    chk("single_sum", dut_sum(), esum);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [151:0] snap;
    logic [15:0]  ta [4];
    logic [15:0]  tb [4];
    int           sent;
    bit           acc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_rows", dut_rows(), '0);
    chk("reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed single products
    single_op(16'd3, 16'd5, 32'h0000000F, 20'h80003, 18'h20000);
    single_op(16'h8000, 16'h8000, 32'h40000000, 20'h80000, 18'h30000);
    single_op(16'h8000, 16'h7FFF, 32'hC0008000, 20'h88000, 18'h10000);

    // Back-to-back, no backpressure: in_ready high, outputs on consecutive cycles
    ta = '{16'd7, 16'd0, 16'hFFFF, 16'h7FFF};
    tb = '{16'hFFF7, 16'd1234, 16'hFFFF, 16'h7FFF};
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        a        = ta[c];
        b        = tb[c];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 4)  chk("b2b_in_ready", in_ready, 1'b1);
      if (c >= 2) chk("b2b_out_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: third op stalls, rows hold steady
    out_ready = 1'b0;
    a = 16'd100;   b = 16'hFFFD; in_valid = 1'b1;
    @(negedge clk); chk("bp_in_ready0", in_ready, 1'b1);
    @(posedge clk); #1;
    a = 16'hFFF9;  b = 16'd9;
    @(negedge clk); chk("bp_in_ready1", in_ready, 1'b1);
    @(posedge clk); #1;
    a = 16'd1234;  b = 16'hEF1F;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_stall_in_ready", in_ready, 1'b0);
      chk("bp_stall_out_valid", out_valid, 1'b1);
      if (c == 0) snap = dut_rows();
      else        chk("bp_stall_rows_stable", dut_rows(), snap);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk); chk("bp_release_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset with both stages full: everything in flight is discarded
    out_ready = 1'b0;
    send(16'd11, 16'd13);
    send(16'hFF00, 16'd77);
    @(negedge clk);
    chk("prerst_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_rows", dut_rows(), '0);
    chk("midrst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst_no_stale", out_valid, 1'b0);
    end
    @(posedge clk); #1;

    // Randomized traffic with random in_valid gaps and random out_ready
    sent = 0;
    for (int cyc = 0; sent < N_RAND && cyc < 60000; cyc++) begin
      if (!in_valid) begin
        a = pick();
        b = pick();
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    chk("rand_sent", sent, N_RAND);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);

    chk("xfer_count", n_in, n_out + n_dropped);
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
